dn_benes_ctrl: RTL and testbench

Sequencer for the Benes distribution network (`dn_benes`). It accepts a routing configuration over a narrow beat-serial bus and assembles it into the full switch-control vector. It then pulses `set_en` to program the network, streams a counted batch of data vectors through it with `route_en`, and tags the network outputs with `out_valid` after a fixed network latency. It sits between the operand scheduler and the `dn_benes` instance and owns every control input of that instance.

---
 rtl/dn_benes_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dn_benes_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dn_benes_ctrl.sv
// Control sequencer for the dn_benes distribution network: assembles a beat-serial
// route configuration, programs the network, streams a counted batch and tags outputs.

module dn_benes_ctrl_lane #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [DW-1:0] d,
   output logic [DW-1:0] q
);
   logic [DW-1:0] hold;

   always_ff @(posedge clk) begin
      if (reset)   hold <= '0;
      else if (en) hold <= d;
   end

   // Pass-through on an accept so the network sees the vector in the same cycle.
   assign q = en ? d : hold;
endmodule

module dn_benes_ctrl #(
   parameter int N         = 32,
   parameter int DW_DATA   = 8,
   parameter int N_LEVELS  = 2*$clog2(N)-1,
   parameter int CFG_W     = 32,
   parameter int CFG_BITS  = N_LEVELS*N,
   parameter int CFG_BEATS = (CFG_BITS+CFG_W-1)/CFG_W,
   parameter int NET_LAT   = N_LEVELS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CFG_W-1:0]       cfg_data,
   input  logic [15:0]            cfg_nvec,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DW_DATA*N-1:0]   in_data,
   output logic                   out_valid,
   output logic [DW_DATA*N-1:0]   out_data,
   output logic                   set_en,
   output logic                   route_en,
   output logic [CFG_BITS-1:0]    route_signals,
   output logic [DW_DATA*N-1:0]   net_in,
   input  logic [DW_DATA*N-1:0]   net_out,
   output logic                   busy
);
   localparam int BCW = (CFG_BEATS > 1) ? $clog2(CFG_BEATS) : 1;
   localparam int DCW = $clog2(NET_LAT+1);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SET, S_RUN, S_DRAIN} state_t;
   state_t state, state_nxt;

   logic                cfg_fire, cfg_last, in_fire, run_last;
   logic [BCW-1:0]      beat_cnt;
   logic [15:0]         vec_cnt;
   logic [DCW-1:0]      drain_cnt;
   logic [CFG_BITS-1:0] shadow, shadow_nxt, active;
   logic [NET_LAT:1]    vld_pipe;

   logic [N-1:0][DW_DATA-1:0] in_lane, net_lane;

   assign cfg_fire = cfg_valid & cfg_ready;
   assign cfg_last = cfg_fire & (beat_cnt == BCW'(CFG_BEATS-1));
   assign in_fire  = in_valid & in_ready;
   assign run_last = in_fire & (vec_cnt == 16'd1);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_LOAD: begin
            if (cfg_last)      state_nxt = S_SET;
            else if (cfg_fire) state_nxt = S_LOAD;
         end
         S_SET:   state_nxt = (vec_cnt != 16'd0) ? S_RUN : S_IDLE;
         S_RUN:   if (run_last) state_nxt = S_DRAIN;
         S_DRAIN: if (drain_cnt == DCW'(1)) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      set_en    = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            cfg_ready = 1'b1;
            busy      = 1'b0;
         end
         S_LOAD:  cfg_ready = 1'b1;
         S_SET:   set_en    = 1'b1;
         S_RUN:   in_ready  = 1'b1;
         default: ;
      endcase
   end

   // Each beat owns a fixed slice; the last slice is clipped at CFG_BITS.
   for (genvar b = 0; b < CFG_BEATS; b++) begin : g_beat
      localparam int LO = b*CFG_W;
      localparam int W  = (CFG_BITS - LO < CFG_W) ? (CFG_BITS - LO) : CFG_W;
      assign shadow_nxt[LO +: W] = (cfg_fire && beat_cnt == BCW'(b)) ? cfg_data[W-1:0]
                                                                     : shadow[LO +: W];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_cnt  <= '0;
         vec_cnt   <= '0;
         drain_cnt <= '0;
         shadow    <= '0;
         active    <= '0;
      end else begin
         if (cfg_fire) begin
            shadow   <= shadow_nxt;
            beat_cnt <= cfg_last ? '0 : beat_cnt + 1'b1;
         end
         if (cfg_last) begin
            active  <= shadow_nxt;
            vec_cnt <= cfg_nvec;
         end else if (in_fire) begin
            vec_cnt <= vec_cnt - 1'b1;
         end
         if (run_last)               drain_cnt <= DCW'(NET_LAT);
         else if (state == S_DRAIN)  drain_cnt <= drain_cnt - 1'b1;
      end
   end

   // Valid tag tracks the network pipeline regardless of state.
   always_ff @(posedge clk) begin
      if (reset) vld_pipe <= '0;
      else       vld_pipe <= NET_LAT'({vld_pipe, route_en});
   end

   assign route_en      = in_fire;
   assign out_valid     = vld_pipe[NET_LAT];
   assign out_data      = net_out;
   assign route_signals = active;

   assign in_lane = in_data;
   assign net_in  = net_lane;

   for (genvar l = 0; l < N; l++) begin : g_lane
      dn_benes_ctrl_lane #(.DW(DW_DATA)) u_lane (
         .clk   (clk),
         .reset (reset),
         .en    (route_en),
         .d     (in_lane[l]),
         .q     (net_lane[l])
      );
   end
endmodule

// File: tb/tb_dn_benes_ctrl.sv
// Randomized scoreboard bench for dn_benes_ctrl with a delay-line model of the network.

module tb_dn_benes_ctrl;
   localparam int N        = 4;
   localparam int DW_DATA  = 8;
   localparam int CFG_W    = 8;
   localparam int CFG_BITS = 12;
   localparam int NET_LAT  = 3;
   localparam int DWN      = DW_DATA*N;

   logic                clk = 1'b0;
   logic                reset;
   logic                cfg_valid, cfg_ready;
   logic [CFG_W-1:0]    cfg_data;
   logic [15:0]         cfg_nvec;
   logic                in_valid, in_ready;
   logic [DWN-1:0]      in_data;
   logic                out_valid;
   logic [DWN-1:0]      out_data;
   logic                set_en, route_en;
   logic [CFG_BITS-1:0] route_signals;
   logic [DWN-1:0]      net_in, net_out;
   logic                busy;

   typedef struct { logic [DWN-1:0] data; int cyc; } exp_t;
   exp_t sb[$];

   int checks = 0, failures = 0, cyc = 0, re_cnt = 0;

   dn_benes_ctrl #(
      .N(N), .DW_DATA(DW_DATA), .N_LEVELS(3), .CFG_W(CFG_W),
      .CFG_BITS(CFG_BITS), .CFG_BEATS(2), .NET_LAT(NET_LAT)
   ) dut (
      .clk(clk), .reset(reset),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data), .cfg_nvec(cfg_nvec),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_data(out_data),
      .set_en(set_en), .route_en(route_en), .route_signals(route_signals),
      .net_in(net_in), .net_out(net_out), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Network stand-in: fixed-latency delay line that only carries data captured on route_en.
   logic [NET_LAT-1:0][DWN-1:0] netpipe;
   always @(posedge clk) netpipe <= {netpipe[NET_LAT-2:0], route_en ? net_in : DWN'($urandom)};
   assign net_out = netpipe[NET_LAT-1];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [CFG_BITS-1:0] route_of(input logic [7:0] b0, input logic [7:0] b1);
      logic [15:0] full;
      full = {b1, b0};
      return full[CFG_BITS-1:0];
   endfunction

   // Monitor: every out_valid must match the oldest outstanding accept, at accept+NET_LAT.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (route_en) re_cnt++;
         if (out_valid) begin
            if (sb.size() == 0) chk("out_valid_unexpected", 1, 0);
            else begin
               e = sb.pop_front();
               chk("out_data", out_data, e.data);
               chk("out_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic send_cfg(input logic [7:0] b0, input logic [7:0] b1, input logic [15:0] nvec,
                           input logic [CFG_BITS-1:0] exp_rt);
      @(posedge clk); #1;
      cfg_valid = 1'b1; cfg_data = b0; cfg_nvec = 16'($urandom);
      @(negedge clk);
      chk("cfg_ready_beat0", cfg_ready, 1);
      @(posedge clk); #1;
      cfg_data = b1; cfg_nvec = nvec;
      @(negedge clk);
      chk("cfg_ready_beat1", cfg_ready, 1);
      chk("busy_load", busy, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0; cfg_nvec = 16'($urandom);
      @(negedge clk);
      chk("set_en_pulse", set_en, 1);
      chk("route_after_cfg", route_signals, exp_rt);
      chk("cfg_ready_set", cfg_ready, 0);
      chk("in_ready_set", in_ready, 0);
   endtask

   // mode 0: in_valid held, 1: alternating 1-0-1-0, 2: random gaps
   task automatic run_batch(input int nvec, input int mode, input bit cfg_poke,
                            input logic [CFG_BITS-1:0] exp_rt);
      int acc = 0, n = 0, first_acc = 0, last_acc = 0, re0;
      bit done = 0;
      re0 = re_cnt;
      while (acc < nvec && n < 200) begin
         @(posedge clk); #1;
         in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 0) : 1'($urandom);
         in_data  = DWN'($urandom);
         if (cfg_poke) begin
            cfg_valid = 1'b1; cfg_data = CFG_W'($urandom); cfg_nvec = 16'($urandom);
         end
         @(negedge clk);
         if (n == 0) chk("set_en_one_cycle", set_en, 0);
         chk("in_ready_run", in_ready, 1);
         if (cfg_poke) begin
            chk("cfg_ready_run", cfg_ready, 0);
            chk("route_stable_run", route_signals, exp_rt);
         end
         if (in_valid && in_ready) begin
            sb.push_back('{data: in_data, cyc: cyc + NET_LAT});
            if (acc == 0) first_acc = cyc;
            last_acc = cyc;
            acc++;
         end
         n++;
      end
      if (acc < nvec) chk("run_timeout", 64'(acc), 64'(nvec));
      if (mode == 0) chk("consecutive_accepts", 64'(last_acc - first_acc), 64'(nvec - 1));
      @(posedge clk); #1;
      in_valid = 1'b0; cfg_valid = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(negedge clk);
         if (k == 0) chk("in_ready_after_last", in_ready, 0);
         if (busy) chk("route_stable_drain", route_signals, exp_rt);
         else begin
            chk("busy_fall", 64'(cyc - last_acc), 64'(NET_LAT + 1));
            chk("cfg_ready_at_idle", cfg_ready, 1);
            done = 1;
         end
      end
      if (!done) chk("drain_timeout", 0, 1);
      chk("sb_empty", 64'(sb.size()), 0);
      chk("route_en_count", 64'(re_cnt - re0), 64'(nvec));
   endtask

   initial begin
      logic [7:0] b0, b1;
      int nv;
      reset = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_nvec = '0;
      in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_set_en", set_en, 0);
      chk("rst_route_en", route_en, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_route_signals", route_signals, 0);
      chk("rst_net_in", net_in, 0);

      // Directed: beats A5, 0C, three vectors back-to-back
      send_cfg(8'hA5, 8'h0C, 16'd3, 12'hCA5);
      run_batch(3, 0, 1'b0, 12'hCA5);

      // Gapped 1-0-1-0-1 stream
      b0 = 8'($urandom); b1 = 8'($urandom);
      send_cfg(b0, b1, 16'd3, route_of(b0, b1));
      run_batch(3, 1, 1'b0, route_of(b0, b1));

      // Zero-length batch: SET only
      b0 = 8'($urandom); b1 = 8'($urandom);
      send_cfg(b0, b1, 16'd0, route_of(b0, b1));
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1 in_valid = 1'b1; in_data = DWN'($urandom);
         @(negedge clk);
         chk("nvec0_in_ready", in_ready, 0);
         if (k == 0) begin
            chk("nvec0_busy", busy, 0);
            chk("nvec0_cfg_ready", cfg_ready, 1);
            chk("nvec0_route", route_signals, route_of(b0, b1));
         end
      end
      @(posedge clk); #1 in_valid = 1'b0;

      // Configuration beats offered during RUN must be refused
      b0 = 8'($urandom); b1 = 8'($urandom);
      send_cfg(b0, b1, 16'd4, route_of(b0, b1));
      run_batch(4, 2, 1'b1, route_of(b0, b1));

      // Random batches
      for (int t = 0; t < 4; t++) begin
         b0 = 8'($urandom); b1 = 8'($urandom); nv = $urandom_range(1, 6);
         send_cfg(b0, b1, 16'(nv), route_of(b0, b1));
         run_batch(nv, 2, 1'b0, route_of(b0, b1));
      end

      // Reset after the first of three accepts
      b0 = 8'($urandom); b1 = 8'($urandom);
      send_cfg(b0, b1, 16'd3, route_of(b0, b1));
      @(posedge clk); #1 in_valid = 1'b1; in_data = DWN'($urandom);
      @(negedge clk);
      chk("rst_mid_accept", in_ready, 1);
      @(posedge clk); #1 reset = 1'b1; in_valid = 1'b0; sb.delete();
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cfg_ready", cfg_ready, 1);
      chk("rst_mid_in_ready", in_ready, 0);
      chk("rst_mid_route", route_signals, 0);
      chk("rst_mid_net_in", net_in, 0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("rst_mid_out_valid", out_valid, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
